// File: rtl/ap_line_sequencer.sv
// ap_line_sequencer: turns one decoded tape operation (optionally repeated)
// into spaced strobes on the AP/data line, waits for LineReady after each
// step, and returns the cell value on completion. A watchdog traps a line
// that never becomes ready again.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for a command; CmdReady high unless trapped
// ISSUE    | one cycle, strobe for the latched op
// SETTLE   | SETTLE_CYC quiet cycles before LineReady is trusted
// WAIT_RDY | waiting for LineReady; watchdog counting
// DONE     | one cycle, RspValid with LineData
// ERR      | watchdog expired; held until reset
module ap_line_sequencer #(
  parameter int REPEAT_W   = 4,
  parameter int SETTLE_CYC = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic                CmdValid,
  output logic                CmdReady,
  input  logic [2:0]          CmdOp,
  input  logic [REPEAT_W-1:0] CmdRepeat,
  input  logic [9:0]          CmdData,
  output logic                ApCountAck,
  output logic                DataCountAck,
  output logic                DataWriteAck,
  output logic                CounterReverse,
  output logic [9:0]          LineDataIn,
  input  logic                LineReady,
  input  logic [9:0]          LineData,
  output logic                RspValid,
  output logic [9:0]          RspData,
  output logic                Busy,
  output logic                Timeout
);

  localparam logic [2:0] OP_NOP    = 3'b000;
  localparam logic [2:0] OP_AP_INC = 3'b001;
  localparam logic [2:0] OP_AP_DEC = 3'b010;
  localparam logic [2:0] OP_D_INC  = 3'b011;
  localparam logic [2:0] OP_D_DEC  = 3'b100;
  localparam logic [2:0] OP_D_WR   = 3'b101;
  localparam logic [2:0] OP_D_RD   = 3'b110;

  localparam logic [REPEAT_W-1:0] CNT_ONE    = REPEAT_W'(1);
  localparam logic [2:0]          SETTLE_LD  = 3'(SETTLE_CYC);
  localparam logic [15:0]         WD_LAST    = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_SETTLE,
    S_WAIT_RDY,
    S_DONE,
    S_ERR
  } state_e;

  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [REPEAT_W-1:0] cnt_q, cnt_d;
  logic [2:0]          settle_q, settle_d;
  logic [15:0]         wd_q, wd_d;
  logic [9:0]          data_q, data_d;
  logic                rev_q, rev_d;

  // State and command registers; reset abandons any command in flight.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= OP_NOP;
      cnt_q    <= '0;
      settle_q <= '0;
      wd_q     <= '0;
      data_q   <= '0;
      rev_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
      wd_q     <= wd_d;
      data_q   <= data_d;
      rev_q    <= rev_d;
    end
  end

  // Next-state, counters and line/response outputs.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    cnt_d        = cnt_q;
    settle_d     = settle_q;
    wd_d         = wd_q;
    data_d       = data_q;
    rev_d        = rev_q;
    CmdReady     = 1'b0;
    ApCountAck   = 1'b0;
    DataCountAck = 1'b0;
    DataWriteAck = 1'b0;
    RspValid     = 1'b0;
    RspData      = '0;
    Timeout      = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Rst_n term keeps CmdReady low while reset is held.
        CmdReady = Rst_n;
        if (CmdValid) begin
          op_d   = CmdOp;
          data_d = CmdData;
          rev_d  = (CmdOp == OP_AP_DEC) || (CmdOp == OP_D_DEC);
          wd_d   = '0;
          if ((CmdRepeat == '0) || (CmdOp == OP_D_WR)) cnt_d = CNT_ONE;
          else                                         cnt_d = CmdRepeat;
          case (CmdOp)
            OP_AP_INC, OP_AP_DEC, OP_D_INC, OP_D_DEC, OP_D_WR: state_d = S_ISSUE;
            OP_D_RD: state_d = S_WAIT_RDY;
            default: state_d = S_DONE;
          endcase
        end
      end

      S_ISSUE: begin
        ApCountAck   = (op_q == OP_AP_INC) || (op_q == OP_AP_DEC);
        DataCountAck = (op_q == OP_D_INC) || (op_q == OP_D_DEC);
        DataWriteAck = (op_q == OP_D_WR);
        settle_d     = SETTLE_LD;
        state_d      = S_SETTLE;
      end

      S_SETTLE: begin
        settle_d = settle_q - 3'd1;
        if (settle_q <= 3'd1) begin
          settle_d = '0;
          state_d  = S_WAIT_RDY;
        end
      end

      S_WAIT_RDY: begin
        if (LineReady) begin
          wd_d = '0;
          // Count saturates at zero rather than wrapping.
          if (cnt_q <= CNT_ONE) begin
            cnt_d   = '0;
            state_d = S_DONE;
          end else begin
            cnt_d   = cnt_q - CNT_ONE;
            state_d = S_ISSUE;
          end
        end else begin
          wd_d = wd_q + 16'd1;
          if (wd_q >= WD_LAST) state_d = S_ERR;
        end
      end

      S_DONE: begin
        RspValid = 1'b1;
        RspData  = LineData;
        state_d  = S_IDLE;
      end

      S_ERR: begin
        Timeout = 1'b1;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Direction and write data are only presented while a command is active.
  always_comb begin
    Busy           = (state_q == S_ISSUE) || (state_q == S_SETTLE) ||
                     (state_q == S_WAIT_RDY) || (state_q == S_DONE);
    CounterReverse = rev_q & Busy;
    LineDataIn     = Busy ? data_q : 10'd0;
  end

endmodule

// File: tb/tb_ap_line_sequencer.sv
// Bench for ap_line_sequencer: directed scenarios followed by random
// commands, each compared against a behavioural model of strobe counts,
// spacing and response latency.
module tb_ap_line_sequencer;

  localparam int RW = 4;
  localparam int S  = 2;
  localparam int TO = 255;

  logic          Clk = 1'b0;
  logic          Rst_n = 1'b0;
  logic          CmdValid = 1'b0;
  logic [2:0]    CmdOp = 3'd0;
  logic [RW-1:0] CmdRepeat = '0;
  logic [9:0]    CmdData = '0;
  logic          LineReady = 1'b1;
  logic [9:0]    LineData = '0;
  logic          CmdReady, ApCountAck, DataCountAck, DataWriteAck, CounterReverse;
  logic [9:0]    LineDataIn, RspData;
  logic          RspValid, Busy, Timeout;

  int vec = 0;
  int err = 0;

  ap_line_sequencer #(.REPEAT_W(RW), .SETTLE_CYC(S), .TIMEOUT(TO)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .CmdValid(CmdValid), .CmdReady(CmdReady),
    .CmdOp(CmdOp), .CmdRepeat(CmdRepeat), .CmdData(CmdData),
    .ApCountAck(ApCountAck), .DataCountAck(DataCountAck), .DataWriteAck(DataWriteAck),
    .CounterReverse(CounterReverse), .LineDataIn(LineDataIn),
    .LineReady(LineReady), .LineData(LineData),
    .RspValid(RspValid), .RspData(RspData), .Busy(Busy), .Timeout(Timeout)
  );

  always #5 Clk = ~Clk;

  task automatic chk_i(input string tag, input int obs, input int exp);
    vec++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    vec++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_d(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    vec++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: repetitions, strobes per line and completion latency.
  function automatic int eff_count(input logic [2:0] op, input int rep);
    if (op == 3'd5) return 1;
    return (rep == 0) ? 1 : rep;
  endfunction

  function automatic int exp_strobes(input logic [2:0] op, input int rep, input int kind);
    case (kind)
      0: return (op == 3'd1 || op == 3'd2) ? eff_count(op, rep) : 0;
      1: return (op == 3'd3 || op == 3'd4) ? eff_count(op, rep) : 0;
      default: return (op == 3'd5) ? 1 : 0;
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] op, input int rep);
    if (op == 3'd0 || op == 3'd7) return 1;
    if (op == 3'd6) return 2;
    return eff_count(op, rep) * (S + 2) + 1;
  endfunction

  function automatic logic any_strobe();
    return ApCountAck | DataCountAck | DataWriteAck;
  endfunction

  // One command with LineReady high; starts and ends at an IDLE negedge.
  task automatic run_cmd(input logic [2:0] op, input int rep, input logic [9:0] data,
                         input logic [9:0] ld);
    int   n_ap = 0, n_dc = 0, n_dw = 0, first = 0, last = 0, lat = 0, tot;
    bit   rev_ok = 1'b1, data_ok = 1'b1, hot_ok = 1'b1, gap_ok = 1'b1;
    logic exp_rev;
    exp_rev = (op == 3'd2) || (op == 3'd4);
    tot = exp_strobes(op, rep, 0) + exp_strobes(op, rep, 1) + exp_strobes(op, rep, 2);
    chk_b("ready_before", CmdReady, 1'b1);
    CmdValid  = 1'b1;
    CmdOp     = op;
    CmdRepeat = rep[RW-1:0];
    CmdData   = data;
    LineData  = ld;
    LineReady = 1'b1;
    @(posedge Clk);
    for (int c = 1; c <= 300; c++) begin
      int s;
      @(negedge Clk);
      CmdValid = 1'b0;
      s = 0;
      if (ApCountAck)   begin s++; n_ap++; end
      if (DataCountAck) begin s++; n_dc++; end
      if (DataWriteAck) begin s++; n_dw++; end
      if (s > 1) hot_ok = 1'b0;
      if (s != 0) begin
        if (first == 0) first = c;
        else if (c - last != S + 2) gap_ok = 1'b0;
        last = c;
      end
      if (CounterReverse !== exp_rev) rev_ok = 1'b0;
      if (LineDataIn !== data) data_ok = 1'b0;
      if (RspValid === 1'b1) begin
        lat = c;
        chk_d("rsp_data", RspData, ld);
        break;
      end
    end
    CmdValid = 1'b0;
    chk_i("latency", lat, exp_latency(op, rep));
    chk_i("ap_strobes", n_ap, exp_strobes(op, rep, 0));
    chk_i("dc_strobes", n_dc, exp_strobes(op, rep, 1));
    chk_i("dw_strobes", n_dw, exp_strobes(op, rep, 2));
    chk_i("first_strobe", first, (tot > 0) ? 1 : 0);
    chk_b("strobe_gap", gap_ok, 1'b1);
    chk_b("one_hot", hot_ok, 1'b1);
    chk_b("reverse", rev_ok, 1'b1);
    chk_b("line_data_in", data_ok, 1'b1);
    @(negedge Clk);
    chk_b("idle_busy", Busy, 1'b0);
    chk_b("idle_rsp", RspValid, 1'b0);
  endtask

  initial begin
    logic [2:0] rop;
    int         rrep, tcyc;
    bit         ok;

    // Reset state
    repeat (2) @(negedge Clk);
    chk_b("rst_cmdready", CmdReady, 1'b0);
    chk_b("rst_busy", Busy, 1'b0);
    chk_b("rst_strobes", any_strobe(), 1'b0);
    chk_b("rst_timeout", Timeout, 1'b0);
    chk_b("rst_rsp", RspValid, 1'b0);
    Rst_n = 1'b1;
    #1;
    chk_b("rel_cmdready", CmdReady, 1'b1);
    @(negedge Clk);

    // Directed commands
    run_cmd(3'd1, 3, 10'h055, 10'h123);
    run_cmd(3'd4, 0, 10'h000, 10'h1F3);
    run_cmd(3'd5, 5, 10'h2A5, 10'h3C0);
    run_cmd(3'd6, 1, 10'h011, 10'h2EE);
    run_cmd(3'd7, 9, 10'h0F0, 10'h001);
    run_cmd(3'd2, 15, 10'h3FF, 10'h200);

    // LineReady stall after a DATA_INC strobe
    chk_b("stall_ready", CmdReady, 1'b1);
    CmdValid = 1'b1; CmdOp = 3'd3; CmdRepeat = 4'd1; CmdData = 10'h0AA; LineData = 10'h155;
    @(posedge Clk);
    @(negedge Clk);
    chk_b("stall_strobe", DataCountAck, 1'b1);
    CmdValid = 1'b0; LineReady = 1'b0;
    ok = 1'b1;
    for (int c = 2; c <= 11; c++) begin
      @(negedge Clk);
      if (RspValid || any_strobe()) ok = 1'b0;
    end
    chk_b("stall_quiet", ok, 1'b1);
    LineReady = 1'b1;
    @(negedge Clk);
    chk_b("stall_rsp", RspValid, 1'b1);
    chk_d("stall_rsp_data", RspData, 10'h155);
    @(negedge Clk);
    chk_b("stall_idle", Busy, 1'b0);

    // Watchdog trap
    CmdValid = 1'b1; CmdOp = 3'd3; CmdRepeat = 4'd2; CmdData = 10'h0C3;
    @(posedge Clk);
    @(negedge Clk);
    chk_b("to_strobe", DataCountAck, 1'b1);
    CmdValid = 1'b0; LineReady = 1'b0;
    ok = 1'b1; tcyc = 0;
    for (int c = 2; c <= 400; c++) begin
      @(negedge Clk);
      if (Timeout === 1'b1) begin tcyc = c; break; end
      if (RspValid || any_strobe()) ok = 1'b0;
    end
    chk_i("to_cycle", tcyc, S + TO + 2);
    chk_b("to_quiet", ok, 1'b1);
    chk_b("to_cmdready", CmdReady, 1'b0);
    chk_b("to_busy", Busy, 1'b0);
    CmdValid = 1'b1; LineReady = 1'b1;
    repeat (5) @(negedge Clk);
    chk_b("to_sticky", Timeout, 1'b1);
    chk_b("to_still_blocked", CmdReady, 1'b0);
    chk_b("to_no_strobe", any_strobe(), 1'b0);
    CmdValid = 1'b0;
    Rst_n = 1'b0;
    #1;
    chk_b("to_rst_clear", Timeout, 1'b0);
    @(negedge Clk);
    Rst_n = 1'b1;
    #1;
    chk_b("to_rst_ready", CmdReady, 1'b1);
    @(negedge Clk);

    // Back-to-back NOP then DATA_READ with CmdValid held
    CmdValid = 1'b1; CmdOp = 3'd0; CmdRepeat = 4'd0; LineData = 10'h2D2;
    ok = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    chk_b("b2b_nop_rsp", RspValid, 1'b1);
    if (any_strobe()) ok = 1'b0;
    CmdOp = 3'd6;
    @(negedge Clk);
    chk_b("b2b_idle_ready", CmdReady, 1'b1);
    if (any_strobe()) ok = 1'b0;
    @(negedge Clk);
    CmdValid = 1'b0;
    chk_b("b2b_read_busy", Busy, 1'b1);
    chk_b("b2b_read_wait", RspValid, 1'b0);
    if (any_strobe()) ok = 1'b0;
    @(negedge Clk);
    chk_b("b2b_read_rsp", RspValid, 1'b1);
    chk_d("b2b_read_data", RspData, 10'h2D2);
    if (any_strobe()) ok = 1'b0;
    chk_b("b2b_no_strobes", ok, 1'b1);
    @(negedge Clk);

    // Reset during SETTLE of AP_DEC x4
    CmdValid = 1'b1; CmdOp = 3'd2; CmdRepeat = 4'd4; CmdData = 10'h3A1;
    @(posedge Clk);
    @(negedge Clk);
    CmdValid = 1'b0;
    chk_b("mid_strobe", ApCountAck, 1'b1);
    @(negedge Clk);
    chk_b("mid_settle_rev", CounterReverse, 1'b1);
    Rst_n = 1'b0;
    #1;
    chk_b("mid_busy", Busy, 1'b0);
    chk_b("mid_rev", CounterReverse, 1'b0);
    chk_d("mid_linedata", LineDataIn, 10'h000);
    chk_b("mid_cmdready", CmdReady, 1'b0);
    @(negedge Clk);
    Rst_n = 1'b1;
    #1;
    chk_b("mid_rel_ready", CmdReady, 1'b1);
    ok = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge Clk);
      if (RspValid || any_strobe() || Busy) ok = 1'b0;
    end
    chk_b("mid_abandoned", ok, 1'b1);

    // Random commands
    for (int i = 0; i < 30; i++) begin
      rop  = 3'($urandom_range(0, 7));
      rrep = (rop == 3'd6) ? int'($urandom_range(0, 1)) : int'($urandom_range(0, 15));
      run_cmd(rop, rrep, 10'($urandom), 10'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
